// File: rtl/spi_slave_param_if.sv
// Purpose : Bundles the SPI pins and parallel TX/RX handshake of spi_slave_param.
// Ports   : sck, sl_se (active low), s_MOSI, s_MISO   - SPI pins
//           mode[1:0] = {CPOL,CPHA}                   - transfer mode
//           tx_data/tx_valid/tx_ready                 - TX holding buffer write
//           rx_data/rx_valid                          - received word + strobe
//           tx_underrun, busy                         - status
// Modports: slave (the SPI slave core), master (master pins + host logic).
interface spi_slave_param_if #(
  parameter int DATA_W = 8
);
  logic              sck;
  logic              sl_se;
  logic              s_MOSI;
  logic              s_MISO;
  logic [1:0]        mode;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
  logic              busy;

  modport slave (
    input  sck, sl_se, s_MOSI, mode, tx_data, tx_valid,
    output s_MISO, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output sck, sl_se, s_MOSI, mode, tx_data, tx_valid,
    input  s_MISO, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave_param.sv
// Purpose : Parametrised SPI slave supporting all four CPOL/CPHA modes, DATA_W-bit
//           words and back-to-back multi-word bursts. SPI pins are synchronised into
//           the clk domain and edge-detected; clk must run >= 8x the sck frequency.
// Ports   : clk  - system clock
//           rst  - asynchronous, active-high reset
//           bus  - spi_slave_param_if.slave (SPI pins, mode, TX buffer, RX strobe,
//                  tx_underrun, busy)
// Params  : DATA_W (>=2), SYNC_STAGES (>=2), TX_IDLE (word sent on TX underrun)
// Config  : define SPI_SLAVE_MSB_FIRST_EN for MSB-first shifting; default is LSB first.
module spi_slave_param #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_IDLE     = {(DATA_W/2){2'b10}}
) (
  input logic              clk,
  input logic              rst,
  spi_slave_param_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_XFER
  } state_t;

  // Synchronisers and edge history
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sel_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_sel_d;

  // Core state
  state_t            r_state;
  logic [1:0]        r_mode;
  logic [CNT_W-1:0]  r_bcnt;
  logic [DATA_W-1:0] r_tx_sr;
  logic [DATA_W-1:0] r_rx_sr;
  logic [DATA_W-1:0] r_buf;
  logic              r_buf_full;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_tx_underrun;
  logic              r_busy;

  logic              w_sck;
  logic              w_sel_n;
  logic              w_mosi;
  logic              w_rise;
  logic              w_fall;
  logic              w_lead;
  logic              w_trail;
  logic              w_sample;
  logic              w_drive;
  logic              w_sel_fall;
  logic              w_load;
  logic              w_wr;
  logic [DATA_W-1:0] w_rx_next;
  logic [DATA_W-1:0] w_tx_next;
  logic              w_tx_bit;

  // Select sync resets to deselected so a low pin right after reset still
  // produces a 1->0 select event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_sel_sync  <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_sel_d     <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
      r_sel_sync  <= {r_sel_sync[SYNC_STAGES-2:0], bus.sl_se};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.s_MOSI};
      r_sck_d     <= w_sck;
      r_sel_d     <= w_sel_n;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_sel_n    = r_sel_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise     = w_sck & ~r_sck_d;
  assign w_fall     = ~w_sck & r_sck_d;
  assign w_sel_fall = r_sel_d & ~w_sel_n;

  // Edge roles follow the mode latched at ARM, not the live mode input.
  assign w_lead   = r_mode[1] ? w_fall : w_rise;
  assign w_trail  = r_mode[1] ? w_rise : w_fall;
  assign w_sample = r_mode[0] ? w_trail : w_lead;
  assign w_drive  = r_mode[0] ? w_lead  : w_trail;

  // ARM preloads for CPHA=0 using the mode being latched in that same cycle.
  assign w_load = ~w_sel_n &
                  (((r_state == S_ARM) & ~bus.mode[0]) |
                   ((r_state == S_XFER) & w_drive & (r_bcnt == '0)));
  assign w_wr   = bus.tx_valid & ~r_buf_full;

`ifdef SPI_SLAVE_MSB_FIRST_EN
  assign w_rx_next = {r_rx_sr[DATA_W-2:0], w_mosi};
  assign w_tx_next = {r_tx_sr[DATA_W-2:0], 1'b0};
  assign w_tx_bit  = r_tx_sr[DATA_W-1];
`else
  assign w_rx_next = {w_mosi, r_rx_sr[DATA_W-1:1]};
  assign w_tx_next = {1'b0, r_tx_sr[DATA_W-1:1]};
  assign w_tx_bit  = r_tx_sr[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_mode        <= '0;
      r_bcnt        <= '0;
      r_tx_sr       <= '0;
      r_rx_sr       <= '0;
      r_buf         <= '0;
      r_buf_full    <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;

      // A write in the same cycle as a load refills the buffer; the load
      // itself still takes the previous content.
      if (w_wr) begin
        r_buf      <= bus.tx_data;
        r_buf_full <= 1'b1;
      end else if (w_load && r_buf_full) begin
        r_buf_full <= 1'b0;
      end

      if (w_load) begin
        if (r_buf_full) begin
          r_tx_sr <= r_buf;
        end else begin
          r_tx_sr       <= TX_IDLE;
          r_tx_underrun <= 1'b1;
        end
      end

      if (w_sel_n) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_bcnt  <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_sel_fall) begin
              r_state <= S_ARM;
              r_busy  <= 1'b1;
              r_bcnt  <= '0;
            end
          end
          S_ARM: begin
            r_mode  <= bus.mode;
            r_state <= S_XFER;
          end
          S_XFER: begin
            if (w_sample) begin
              r_rx_sr <= w_rx_next;
              if (r_bcnt == CNT_W'(DATA_W-1)) begin
                r_bcnt     <= '0;
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
              end else begin
                r_bcnt <= r_bcnt + 1'b1;
              end
            end else if (w_drive && (r_bcnt != '0)) begin
              r_tx_sr <= w_tx_next;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.s_MISO      = r_busy & w_tx_bit;
  assign bus.tx_ready    = ~r_buf_full;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_underrun = r_tx_underrun;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_spi_slave_param.sv
module tb_spi_slave_param;
  localparam int DATA_W = 8;
  localparam int HALF   = 80;  // sck half period in ns (clk period 10 ns)
  localparam logic [DATA_W-1:0] IDLE_WORD = 8'hAA;

  logic clk;
  logic rst;

  spi_slave_param_if #(.DATA_W(DATA_W)) bus ();

  spi_slave_param #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (2),
    .TX_IDLE     (IDLE_WORD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor: counts strobes and collects received words
  int                rxv_cnt = 0;
  int                und_cnt = 0;
  logic [DATA_W-1:0] rx_got_q[$];

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rxv_cnt++;
      rx_got_q.push_back(bus.rx_data);
    end
    if (bus.tx_underrun === 1'b1) und_cnt++;
  end

  // Master / host stimulus state
  logic [DATA_W-1:0] mosi_q[$];
  logic [DATA_W-1:0] miso_q[$];
  logic [DATA_W-1:0] feed_q[$];
  logic [DATA_W-1:0] w_mosi[5];
  logic [DATA_W-1:0] w_tx[5];
  int                got_rxv;
  int                got_und;

  // Reference rule: number of buffer loads in a transfer of nw words.
  // CPHA=0 preloads at select and again on every word's final drive edge.
  function automatic int exp_loads(input logic [1:0] m, input int nw);
    return nw + (m[0] ? 0 : 1);
  endfunction

  function automatic int bit_pos(input int b);
`ifdef SPI_SLAVE_MSB_FIRST_EN
    return DATA_W - 1 - b;
`else
    return b;
`endif
  endfunction

  task automatic host_feed();
    int budget;
    while (feed_q.size() > 0) begin
      budget = 0;
      @(negedge clk);
      while (bus.tx_ready !== 1'b1 && budget < 3000) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 3000) begin
        checks++; errors++;
        $display("FAIL host_feed_timeout: tx_ready=%b required 1", bus.tx_ready);
        feed_q.delete();
      end else begin
        bus.tx_data  = feed_q.pop_front();
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
      end
    end
  endtask

  task automatic spi_select(input logic [1:0] m);
    bus.mode = m;
    bus.sck  = m[1];
    repeat (6) @(posedge clk);
    bus.sl_se = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic spi_deselect();
    #HALF;
    bus.sl_se = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [1:0] m, input int nbits);
    logic [DATA_W-1:0] wo;
    logic [DATA_W-1:0] wi;
    int b;
    wo = '0;
    wi = '0;
    for (int i = 0; i < nbits; i++) begin
      b = i % DATA_W;
      if (b == 0) wo = (mosi_q.size() > 0) ? mosi_q.pop_front() : '0;
      if (!m[0]) begin
        bus.s_MOSI = wo[bit_pos(b)];
        #HALF;
        wi[bit_pos(b)] = bus.s_MISO;
        bus.sck = ~bus.sck;
        #HALF;
        bus.sck = ~bus.sck;
      end else begin
        bus.sck    = ~bus.sck;
        bus.s_MOSI = wo[bit_pos(b)];
        #HALF;
        wi[bit_pos(b)] = bus.s_MISO;
        bus.sck = ~bus.sck;
        #HALF;
      end
      if (b == DATA_W - 1) miso_q.push_back(wi);
    end
  endtask

  task automatic run_xfer(input logic [1:0] m, input int nw, input int ntx);
    int rx0, u0;
    mosi_q.delete(); miso_q.delete(); feed_q.delete(); rx_got_q.delete();
    for (int i = 0; i < nw; i++) mosi_q.push_back(w_mosi[i]);
    for (int i = 0; i < ntx; i++) feed_q.push_back(w_tx[i]);
    rx0 = rxv_cnt;
    u0  = und_cnt;
    fork
      host_feed();
      begin
        spi_select(m);
        spi_bits(m, nw * DATA_W);
        spi_deselect();
      end
    join
    got_rxv = rxv_cnt - rx0;
    got_und = und_cnt - u0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.s_MISO !== 1'b0 || bus.rx_valid !== 1'b0 || bus.tx_underrun !== 1'b0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: miso=%b rxv=%b und=%b busy=%b required 0 0 0 0",
               bus.s_MISO, bus.rx_valid, bus.tx_underrun, bus.busy);
    end
    checks++;
    if (bus.rx_data !== '0 || bus.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_data: rx_data=%h tx_ready=%b required 00 1", bus.rx_data, bus.tx_ready);
    end
    @(posedge clk); rst = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_modes();
    for (int mi = 0; mi < 4; mi++) begin
      logic [1:0] m;
      m = 2'(mi);
      w_mosi[0] = 8'h3C;
      w_tx[0]   = 8'h5A;
      run_xfer(m, 1, 1);
      checks++;
      if (got_rxv !== 1) begin
        errors++; $display("FAIL mode%0d_rxv_count: got %0d required 1", mi, got_rxv);
      end
      checks++;
      if (rx_got_q.size() < 1 || rx_got_q[0] !== 8'h3C) begin
        errors++; $display("FAIL mode%0d_rx: got %h required 3c", mi, bus.rx_data);
      end
      checks++;
      if (miso_q.size() < 1 || miso_q[0] !== 8'h5A) begin
        errors++; $display("FAIL mode%0d_miso: got %h required 5a",
                           mi, (miso_q.size() > 0) ? miso_q[0] : 'x);
      end
      checks++;
      if (got_und !== exp_loads(m, 1) - 1) begin
        errors++; $display("FAIL mode%0d_underrun: got %0d required %0d",
                           mi, got_und, exp_loads(m, 1) - 1);
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.s_MISO !== 1'b0) begin
        errors++; $display("FAIL mode%0d_idle: busy=%b miso=%b required 0 0",
                           mi, bus.busy, bus.s_MISO);
      end
    end
  endtask

  task automatic test_underrun();
    w_mosi[0] = 8'hE7;
    run_xfer(2'd1, 1, 0);
    checks++;
    if (miso_q.size() < 1 || miso_q[0] !== IDLE_WORD) begin
      errors++; $display("FAIL underrun_miso: got %h required %h",
                         (miso_q.size() > 0) ? miso_q[0] : 'x, IDLE_WORD);
    end
    checks++;
    if (got_und !== 1) begin
      errors++; $display("FAIL underrun_pulses: got %0d required 1", got_und);
    end
    checks++;
    if (got_rxv !== 1 || rx_got_q.size() < 1 || rx_got_q[0] !== 8'hE7) begin
      errors++; $display("FAIL underrun_rx: count %0d data %h required 1 e7", got_rxv, bus.rx_data);
    end
  endtask

  task automatic test_burst();
    logic [DATA_W-1:0] tx_words[3];
    w_mosi[0] = 8'h01; w_mosi[1] = 8'h80; w_mosi[2] = 8'hFF;
    tx_words = '{8'h5A, 8'hC3, 8'h3C};
    for (int i = 0; i < 3; i++) w_tx[i] = tx_words[i];
    run_xfer(2'd1, 3, 3);
    checks++;
    if (got_rxv !== 3) begin
      errors++; $display("FAIL burst_rxv_count: got %0d required 3", got_rxv);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_got_q.size() <= i || rx_got_q[i] !== w_mosi[i]) begin
        errors++; $display("FAIL burst_rx%0d: got %h required %h",
                           i, (rx_got_q.size() > i) ? rx_got_q[i] : 'x, w_mosi[i]);
      end
      checks++;
      if (miso_q.size() <= i || miso_q[i] !== tx_words[i]) begin
        errors++; $display("FAIL burst_miso%0d: got %h required %h",
                           i, (miso_q.size() > i) ? miso_q[i] : 'x, tx_words[i]);
      end
    end
    checks++;
    if (got_und !== 0) begin
      errors++; $display("FAIL burst_underrun: got %0d required 0", got_und);
    end
  endtask

  task automatic test_deselect();
    int rx0;
    mosi_q.delete(); miso_q.delete(); rx_got_q.delete();
    mosi_q.push_back(8'hA5);
    rx0 = rxv_cnt;
    spi_select(2'd0);
    spi_bits(2'd0, 4);
    spi_deselect();
    checks++;
    if (rxv_cnt - rx0 !== 0) begin
      errors++; $display("FAIL deselect_partial_rxv: got %0d required 0", rxv_cnt - rx0);
    end
    mosi_q.push_back(8'hC3);
    spi_select(2'd0);
    spi_bits(2'd0, 8);
    spi_deselect();
    checks++;
    if (rxv_cnt - rx0 !== 1 || bus.rx_data !== 8'hC3) begin
      errors++; $display("FAIL deselect_next_word: count %0d data %h required 1 c3",
                         rxv_cnt - rx0, bus.rx_data);
    end
  endtask

  task automatic test_reset_mid();
    mosi_q.delete(); miso_q.delete(); feed_q.delete();
    mosi_q.push_back(8'h00);
    feed_q.push_back(8'hFF);
    feed_q.push_back(8'hFF);
    fork
      host_feed();
      begin
        spi_select(2'd0);
        spi_bits(2'd0, 4);
      end
    join
    repeat (6) @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.s_MISO !== 1'b1 || bus.tx_ready !== 1'b0) begin
      errors++; $display("FAIL midword_pre: busy=%b miso=%b tx_ready=%b required 1 1 0",
                         bus.busy, bus.s_MISO, bus.tx_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.s_MISO !== 1'b0 || bus.tx_ready !== 1'b1 ||
        bus.rx_data !== '0 || bus.rx_valid !== 1'b0 || bus.tx_underrun !== 1'b0) begin
      errors++; $display("FAIL midword_reset: busy=%b miso=%b rdy=%b rx=%h rxv=%b und=%b required 0 0 1 00 0 0",
                         bus.busy, bus.s_MISO, bus.tx_ready, bus.rx_data, bus.rx_valid, bus.tx_underrun);
    end
    bus.sl_se = 1'b1;
    bus.sck   = 1'b0;
    repeat (4) @(posedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic test_mode_change();
    int rx0;
    mosi_q.delete(); miso_q.delete(); feed_q.delete(); rx_got_q.delete();
    mosi_q.push_back(8'h96);
    feed_q.push_back(8'h69);
    rx0 = rxv_cnt;
    fork
      host_feed();
      begin
        spi_select(2'd1);
        bus.mode = 2'd2;
        spi_bits(2'd1, 8);
        spi_deselect();
      end
    join
    checks++;
    if (rxv_cnt - rx0 !== 1 || bus.rx_data !== 8'h96) begin
      errors++; $display("FAIL mode_change_rx: count %0d data %h required 1 96",
                         rxv_cnt - rx0, bus.rx_data);
    end
    checks++;
    if (miso_q.size() < 1 || miso_q[0] !== 8'h69) begin
      errors++; $display("FAIL mode_change_miso: got %h required 69",
                         (miso_q.size() > 0) ? miso_q[0] : 'x);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      logic [1:0] m;
      int nw, ntx, loads;
      m     = 2'($urandom_range(0, 3));
      nw    = $urandom_range(1, 3);
      loads = exp_loads(m, nw);
      ntx   = $urandom_range(0, loads);
      for (int i = 0; i < 5; i++) begin
        w_mosi[i] = DATA_W'($urandom);
        w_tx[i]   = DATA_W'($urandom);
      end
      run_xfer(m, nw, ntx);
      checks++;
      if (got_rxv !== nw) begin
        errors++; $display("FAIL rand%0d_rxv_count: got %0d required %0d", it, got_rxv, nw);
      end
      checks++;
      if (got_und !== loads - ntx) begin
        errors++; $display("FAIL rand%0d_underrun: mode %0d got %0d required %0d",
                           it, m, got_und, loads - ntx);
      end
      for (int i = 0; i < nw; i++) begin
        logic [DATA_W-1:0] exp_miso;
        exp_miso = (i < ntx) ? w_tx[i] : IDLE_WORD;
        checks++;
        if (rx_got_q.size() <= i || rx_got_q[i] !== w_mosi[i]) begin
          errors++; $display("FAIL rand%0d_rx%0d: got %h required %h", it, i,
                             (rx_got_q.size() > i) ? rx_got_q[i] : 'x, w_mosi[i]);
        end
        checks++;
        if (miso_q.size() <= i || miso_q[i] !== exp_miso) begin
          errors++; $display("FAIL rand%0d_miso%0d: mode %0d got %h required %h", it, i, m,
                             (miso_q.size() > i) ? miso_q[i] : 'x, exp_miso);
        end
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.sck      = 1'b0;
    bus.sl_se    = 1'b1;
    bus.s_MOSI   = 1'b0;
    bus.mode     = 2'd0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_modes();
    test_underrun();
    test_burst();
    test_deselect();
    test_reset_mid();
    test_mode_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
